// File: rtl/puf_tmv_ctrl.sv
// rtl/puf_tmv_ctrl.sv - majority-vote controller for a PUF core
// Optional per-bit instability mask port "unstable" is built when PUF_TMV_INSTAB_EN is defined.
module puf_tmv_ctrl #(
  parameter int ADDR_W = 4,
  parameter int RESP_W = 8,
  parameter int VOTES  = 7,
  parameter int TMO    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              START,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [RESP_W-1:0] OUT,
  output logic              core_req,
  output logic [ADDR_W-1:0] core_addr,
  input  logic              core_valid,
  input  logic [RESP_W-1:0] core_bits
`ifdef PUF_TMV_INSTAB_EN
  ,
  output logic [RESP_W-1:0] unstable
`endif
);

  localparam int            CW       = $clog2(VOTES + 1);
  localparam logic [CW-1:0] VOTES_C  = CW'(VOTES);
  localparam logic [CW-1:0] HALF_C   = CW'(VOTES / 2);
  localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [RESP_W-1:0]        out_q, out_d;
  logic                     core_req_q, core_req_d;
  logic [ADDR_W-1:0]        core_addr_q, core_addr_d;
  logic [RESP_W-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]            sample_q, sample_d;
  logic [7:0]               wait_q, wait_d;
  logic [CW-1:0]            sample_inc;
`ifdef PUF_TMV_INSTAB_EN
  logic [RESP_W-1:0]        unstable_q, unstable_d;
`endif

  assign sample_inc = sample_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    out_d       = out_q;
    core_req_d  = 1'b0;
    core_addr_d = core_addr_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    wait_d      = wait_q;
`ifdef PUF_TMV_INSTAB_EN
    unstable_d  = unstable_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A START coinciding with the completion pulse belongs to the old run
        if (START && !done_q) begin
          core_addr_d = addr;
          cnt_d       = '0;
          sample_d    = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          core_req_d  = 1'b1;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (core_valid) begin
          for (int i = 0; i < RESP_W; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(core_bits[i]);
          end
          sample_d = sample_inc;
          if (sample_inc == VOTES_C) begin
            state_d = S_FIN;
          end else begin
            core_req_d = 1'b1;
            state_d    = S_REQ;
          end
        end else if (wait_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_FIN: begin
        for (int i = 0; i < RESP_W; i++) begin
          out_d[i] = (cnt_q[i] > HALF_C);
`ifdef PUF_TMV_INSTAB_EN
          unstable_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != VOTES_C);
`endif
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= '0;
      core_req_q  <= 1'b0;
      core_addr_q <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      wait_q      <= '0;
`ifdef PUF_TMV_INSTAB_EN
      unstable_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_q       <= out_d;
      core_req_q  <= core_req_d;
      core_addr_q <= core_addr_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      wait_q      <= wait_d;
`ifdef PUF_TMV_INSTAB_EN
      unstable_q  <= unstable_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign OUT       = out_q;
  assign core_req  = core_req_q;
  assign core_addr = core_addr_q;
`ifdef PUF_TMV_INSTAB_EN
  assign unstable  = unstable_q;
`endif

endmodule

// File: tb/tb_puf_tmv_ctrl.sv
// tb/tb_puf_tmv_ctrl.sv - self-checking bench for puf_tmv_ctrl
// Unstable-mask checks are compiled only when PUF_TMV_INSTAB_EN is defined.
module tb_puf_tmv_ctrl;
  localparam int ADDR_W = 4;
  localparam int RESP_W = 8;
  localparam int VOTES  = 7;
  localparam int TMO    = 16;
  localparam int M_ZERO   = 0;
  localparam int M_SILENT = 1;
  localparam int M_EAGER  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              START;
  logic [ADDR_W-1:0] addr;
  logic              busy, done, err, core_req;
  logic [RESP_W-1:0] OUT;
  logic [ADDR_W-1:0] core_addr;
  logic              core_valid;
  logic [RESP_W-1:0] core_bits;
`ifdef PUF_TMV_INSTAB_EN
  logic [RESP_W-1:0] unstable;
  logic [RESP_W-1:0] last_unst;
`endif

  puf_tmv_ctrl #(.ADDR_W(ADDR_W), .RESP_W(RESP_W), .VOTES(VOTES), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .START(START), .addr(addr),
    .busy(busy), .done(done), .err(err), .OUT(OUT),
    .core_req(core_req), .core_addr(core_addr),
    .core_valid(core_valid), .core_bits(core_bits)
`ifdef PUF_TMV_INSTAB_EN
    , .unstable(unstable)
`endif
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [RESP_W-1:0] stim[$];
  logic [RESP_W-1:0] got[$];
  int                mode = M_ZERO;
  bit                pend = 1'b0;
  int                req_count = 0;
  bit                checking = 1'b0;
  bit                run_active = 1'b0;
  bit                abort_exp = 1'b0;
  logic [RESP_W-1:0] last_out = '0;
  logic              last_err = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Majority per bit over the samples the core actually delivered
  function automatic logic [RESP_W-1:0] vote_out();
    logic [RESP_W-1:0] r;
    r = '0;
    for (int b = 0; b < RESP_W; b++) begin
      int ones;
      ones = 0;
      foreach (got[k]) ones += int'(got[k][b]);
      r[b] = (ones > VOTES / 2);
    end
    return r;
  endfunction

  function automatic logic [RESP_W-1:0] vote_unst();
    logic [RESP_W-1:0] r;
    r = '0;
    for (int b = 0; b < RESP_W; b++) begin
      int ones;
      ones = 0;
      foreach (got[k]) ones += int'(got[k][b]);
      r[b] = (ones != 0) && (ones != got.size());
    end
    return r;
  endfunction

  // PUF core model: answers one cycle after each core_req unless silent
  initial begin
    core_valid = 1'b0;
    core_bits  = '0;
    forever begin
      @(posedge clk); #1;
      core_valid = 1'b0;
      core_bits  = '0;
      if (pend && mode != M_SILENT) begin
        core_valid = 1'b1;
        core_bits  = (stim.size() > 0) ? stim.pop_front() : '0;
        got.push_back(core_bits);
      end
      pend = 1'b0;
      if (core_req === 1'b1) begin
        req_count++;
        pend = 1'b1;
        if (mode == M_EAGER) begin
          core_valid = 1'b1;
          core_bits  = '1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking && reset === 1'b0) begin
      if (done === 1'b1) begin
        logic [RESP_W-1:0] e;
        check("done_only_in_run", 32'(run_active), 32'd1);
        if (abort_exp) begin
          check("abort_err", 32'(err), 32'd1);
          check("abort_out_kept", 32'(OUT), 32'(last_out));
`ifdef PUF_TMV_INSTAB_EN
          check("abort_unst_kept", 32'(unstable), 32'(last_unst));
`endif
        end else begin
          e = vote_out();
          check("vote_out", 32'(OUT), 32'(e));
          check("vote_err", 32'(err), 32'd0);
          check("vote_samples", 32'(got.size()), 32'(VOTES));
          last_out = e;
`ifdef PUF_TMV_INSTAB_EN
          check("vote_unstable", 32'(unstable), 32'(vote_unst()));
          last_unst = vote_unst();
`endif
        end
        check("busy_at_done", 32'(busy), 32'd0);
        last_err = abort_exp;
      end else begin
        check("out_hold", 32'(OUT), 32'(last_out));
        check("err_hold", 32'(err), 32'(last_err));
`ifdef PUF_TMV_INSTAB_EN
        check("unst_hold", 32'(unstable), 32'(last_unst));
`endif
      end
      if (busy === 1'b1) check("core_addr", 32'(core_addr), 32'(exp_addr));
    end
  end

  task automatic load(input logic [RESP_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  task automatic run(input logic [ADDR_W-1:0] a, input int m, input bit abrt,
                     input bit mid_start, input bit start_at_done, output int lat);
    mode      = m;
    abort_exp = abrt;
    @(posedge clk); #1;
    START      = 1'b1;
    addr       = a;
    exp_addr   = a;
    got.delete();
    req_count  = 0;
    run_active = 1'b1;
    @(posedge clk); #1;
    START    = 1'b0;
    addr     = ~a;
    last_err = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 64) begin
      START = (mid_start && lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    START = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (start_at_done) START = 1'b1;
    @(posedge clk); #1;
    START      = 1'b0;
    run_active = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("no_req_after_done", 32'(core_req), 32'd0);
    check("still_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int w;
    reset = 1'b1;
    START = 1'b0;
    addr  = '0;
`ifdef PUF_TMV_INSTAB_EN
    last_unst = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out", 32'(OUT), 32'd0);
    check("rst_core_req", 32'(core_req), 32'd0);
    check("rst_core_addr", 32'(core_addr), 32'd0);
`ifdef PUF_TMV_INSTAB_EN
    check("rst_unstable", 32'(unstable), 32'd0);
`endif
    checking = 1'b1;

    // Stable response, latency, mid-run START, address capture
    load(8'hA5, 7);
    run(4'h9, M_ZERO, 1'b0, 1'b1, 1'b0, lat);
    check("A_latency", 32'(lat), 32'd16);
    check("A_req_pulses", 32'(req_count), 32'd7);
    check("A_out", 32'(OUT), 32'hA5);
    check("A_err", 32'(err), 32'd0);
`ifdef PUF_TMV_INSTAB_EN
    check("A_unstable", 32'(unstable), 32'h00);
`endif

    // 4 ones beat 3 zeros, START held into the done cycle
    load(8'hFF, 4); load(8'h00, 3);
    run(4'h2, M_ZERO, 1'b0, 1'b0, 1'b1, lat);
    check("B_out", 32'(OUT), 32'hFF);
`ifdef PUF_TMV_INSTAB_EN
    check("B_unstable", 32'(unstable), 32'hFF);
`endif

    load(8'hFF, 3); load(8'h00, 4);
    run(4'h5, M_ZERO, 1'b0, 1'b0, 1'b0, lat);
    check("C_out", 32'(OUT), 32'h00);

    // Mixed bits; core also drives junk during the request cycle
    stim.push_back(8'h0F); stim.push_back(8'h33); stim.push_back(8'h55);
    stim.push_back(8'h0F); stim.push_back(8'h33); stim.push_back(8'h55);
    stim.push_back(8'h01);
    run(4'hC, M_EAGER, 1'b0, 1'b0, 1'b0, lat);
    check("D_out", 32'(OUT), 32'h17);
    check("D_latency", 32'(lat), 32'd16);
`ifdef PUF_TMV_INSTAB_EN
    check("D_unstable", 32'(unstable), 32'h7E);
`endif

    // Silent core: abort after TMO cycles in WAIT
    run(4'h7, M_SILENT, 1'b1, 1'b0, 1'b0, lat);
    check("E_latency", 32'(lat), 32'(TMO + 2));
    check("E_req_pulses", 32'(req_count), 32'd1);
    check("E_out_kept", 32'(OUT), 32'h17);
    check("E_err_held", 32'(err), 32'd1);

    load(8'hC3, 7);
    run(4'h1, M_ZERO, 1'b0, 1'b0, 1'b0, lat);
    check("F_out", 32'(OUT), 32'hC3);
    check("F_err_cleared", 32'(err), 32'd0);

    // Reset after the third sample
    mode = M_ZERO;
    abort_exp = 1'b0;
    stim.delete();
    load(8'hFF, 7);
    @(posedge clk); #1;
    START = 1'b1; addr = 4'h3; exp_addr = 4'h3;
    got.delete(); req_count = 0; run_active = 1'b1;
    @(posedge clk); #1;
    START = 1'b0; last_err = 1'b0;
    w = 0;
    while (got.size() < 3 && w < 64) begin
      @(negedge clk);
      w++;
    end
    check("G_three_samples", 32'(got.size()), 32'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_out = '0; last_err = 1'b0; run_active = 1'b0;
`ifdef PUF_TMV_INSTAB_EN
    last_unst = '0;
`endif
    check("G_busy_cleared", 32'(busy), 32'd0);
    check("G_out_cleared", 32'(OUT), 32'd0);
    check("G_no_done", 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    stim.delete();
    load(8'h3C, 7);
    run(4'hE, M_ZERO, 1'b0, 1'b0, 1'b0, lat);
    check("H_req_pulses", 32'(req_count), 32'd7);
    check("H_out", 32'(OUT), 32'h3C);
    check("H_latency", 32'(lat), 32'd16);

    repeat (2) @(posedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
